qahmos_ice_ostc: RTL and testbench

//  Parametrised successor of the ICE main-OSC model. Adds an oscillation-stabilisation wait counter,

---
 rtl/qahmos_ice_ostc.sv | 159 +++++++++++++++
 tb/tb_qahmos_ice_ostc.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qahmos_ice_ostc.sv
// ICE main-OSC model with stabilisation wait counter, OSTC status, glitch-free clock gate and X1/X2 noise filter.
// Optional: QAHMOS_ICE_OSTC_RDYINT_EN adds the MRDYINT one-cycle pulse on every entry into RUN.
`timescale 1ns/1ps
module qahmos_ice_ostc #(
  parameter int CNT_W     = 18,
  parameter int OSTS_W    = 3,
  parameter int BASE      = 8,
  parameter int NF_STAGES = 3
) (
  input  logic                 CPUMCLK,
  input  logic                 RESETB,
  input  logic                 OSCSEL,
  input  logic                 EXCLK,
  input  logic                 MSTOP,
  input  logic                 MDLYCUT,
  input  logic [OSTS_W-1:0]    OSTS,
  input  logic                 X1,
  input  logic                 X2,
  input  logic                 X1ENI,
  input  logic                 X2ENI,
  output logic                 X1DIN,
  output logic                 X2DIN,
  output logic                 CPUTMCLK,
  output logic                 OSCOUTM,
  output logic                 MRDY,
  output logic [2**OSTS_W-1:0] OSTC
`ifdef QAHMOS_ICE_OSTC_RDYINT_EN
  ,
  output logic                 MRDYINT
`endif
);

  localparam int NSTAT = 2**OSTS_W;

  typedef enum logic [1:0] {ST_STOP, ST_WAIT, ST_RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [OSTS_W-1:0]  osts_q;
  logic [CNT_W-1:0]   t_last;
  logic               main_en;
  logic               gate_q;
  logic               gate_l;

  assign CPUTMCLK = OSCSEL & (EXCLK ? ~X2 : X2);
  assign main_en  = OSCSEL & ~MSTOP;
  assign t_last   = CNT_W'((32'd1 << (BASE + 32'(osts_q))) - 32'd1);

  always_ff @(posedge CPUMCLK) begin
    if (!RESETB) begin
      state  <= ST_STOP;
      cnt    <= '0;
      osts_q <= '0;
      MRDY   <= 1'b0;
`ifdef QAHMOS_ICE_OSTC_RDYINT_EN
      MRDYINT <= 1'b0;
`endif
    end else begin
`ifdef QAHMOS_ICE_OSTC_RDYINT_EN
      MRDYINT <= 1'b0;
`endif
      case (state)
        ST_STOP: begin
          if (main_en) begin
            if (EXCLK | MDLYCUT) begin
              state <= ST_RUN;
              MRDY  <= 1'b1;
`ifdef QAHMOS_ICE_OSTC_RDYINT_EN
              MRDYINT <= 1'b1;
`endif
            end else begin
              state  <= ST_WAIT;
              cnt    <= '0;
              osts_q <= OSTS;
            end
          end
        end
        ST_WAIT: begin
          // main_en loss takes priority over a coincident terminal count
          if (!main_en) begin
            state <= ST_STOP;
            cnt   <= '0;
          end else if (cnt == t_last) begin
            state <= ST_RUN;
            MRDY  <= 1'b1;
`ifdef QAHMOS_ICE_OSTC_RDYINT_EN
            MRDYINT <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (!main_en) begin
            state <= ST_STOP;
            MRDY  <= 1'b0;
          end
        end
        default: begin
          state <= ST_STOP;
          MRDY  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    OSTC = '0;
    for (int unsigned i = 0; i < NSTAT; i++) begin
      OSTC[i] = (state == ST_RUN) |
                ((state == ST_WAIT) & (cnt >= CNT_W'((32'd1 << (BASE + i)) - 32'd1)));
    end
  end

  // Enable captured only while the clock is low, so OSCOUTM high pulses are never cut short
  assign gate_q = (state == ST_RUN);

  always_latch begin
    if (!CPUMCLK) gate_l <= gate_q;
  end

  assign OSCOUTM = CPUMCLK & gate_l;

  logic [1:0] raw;
  logic [1:0] filt;

  assign raw[0] = X1 & X1ENI & ~(OSCSEL & ~EXCLK);
  assign raw[1] = X2 & X2ENI & ~OSCSEL;

  for (genvar g = 0; g < 2; g++) begin : g_nf
    logic                 sync1;
    logic                 sync2;
    logic                 dout;
    logic [NF_STAGES-2:0] hist;
    logic [NF_STAGES-1:0] win;

    assign win     = {hist, sync2};
    assign filt[g] = dout;

    always_ff @(posedge CPUMCLK) begin
      if (!RESETB || MDLYCUT) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
        hist  <= '0;
        dout  <= 1'b0;
      end else begin
        sync1 <= raw[g];
        sync2 <= sync1;
        hist  <= win[NF_STAGES-2:0];
        if (&win)       dout <= 1'b1;
        else if (~|win) dout <= 1'b0;
      end
    end
  end

  assign X1DIN = MDLYCUT ? raw[0] : filt[0];
  assign X2DIN = MDLYCUT ? raw[1] : filt[1];

endmodule

// File: tb/tb_qahmos_ice_ostc.sv
// Directed self-checking bench for qahmos_ice_ostc (default parameters).
`timescale 1ns/1ps
module tb_qahmos_ice_ostc;

  logic       clk;
  logic       resetb;
  logic       oscsel;
  logic       exclk;
  logic       mstop;
  logic       mdlycut;
  logic [2:0] osts;
  logic       x1, x2, x1eni, x2eni;
  logic       x1din, x2din, cputmclk, oscoutm, mrdy;
  logic [7:0] ostc;
`ifdef QAHMOS_ICE_OSTC_RDYINT_EN
  logic       mrdyint;
  int         rdy_cnt = 0;
`endif

  int total = 0;
  int bad   = 0;
  int runts = 0;
  bit hi    = 0;
  time t_rise;

  qahmos_ice_ostc #(.CNT_W(18), .OSTS_W(3), .BASE(8), .NF_STAGES(3)) dut (
    .CPUMCLK (clk),
    .RESETB  (resetb),
    .OSCSEL  (oscsel),
    .EXCLK   (exclk),
    .MSTOP   (mstop),
    .MDLYCUT (mdlycut),
    .OSTS    (osts),
    .X1      (x1),
    .X2      (x2),
    .X1ENI   (x1eni),
    .X2ENI   (x2eni),
    .X1DIN   (x1din),
    .X2DIN   (x2din),
    .CPUTMCLK(cputmclk),
    .OSCOUTM (oscoutm),
    .MRDY    (mrdy),
    .OSTC    (ostc)
`ifdef QAHMOS_ICE_OSTC_RDYINT_EN
    ,
    .MRDYINT (mrdyint)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // every OSCOUTM high pulse must last a full clock-high phase
  always @(oscoutm) begin
    if (oscoutm === 1'b1) begin
      t_rise = $time;
      hi = 1;
    end else if (hi) begin
      if ($time - t_rise != 5) runts++;
      hi = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
`ifdef QAHMOS_ICE_OSTC_RDYINT_EN
    if (mrdyint === 1'b1) rdy_cnt++;
`endif
  endtask

  task automatic test_reset();
    resetb = 0; oscsel = 1; exclk = 0; mstop = 0; mdlycut = 0; osts = 3'd0;
    x1 = 0; x2 = 0; x1eni = 0; x2eni = 0;
    repeat (3) tick();
    total++;
    if (mrdy !== 1'b0) begin bad++; $display("FAIL reset_mrdy got=%b exp=0", mrdy); end
    total++;
    if (ostc !== 8'h00) begin bad++; $display("FAIL reset_ostc got=%h exp=00", ostc); end
    total++;
    if (oscoutm !== 1'b0) begin bad++; $display("FAIL reset_oscoutm got=%b exp=0", oscoutm); end
  endtask

  task automatic test_wait();
    resetb = 1;
    for (int j = 1; j <= 258; j++) begin
      tick();
      if (j == 1 || j == 255) begin
        total++;
        if (mrdy !== 1'b0 || ostc !== 8'h00) begin
          bad++; $display("FAIL wait_early j=%0d mrdy=%b ostc=%h exp 0/00", j, mrdy, ostc);
        end
      end
      if (j == 256) begin
        total++;
        if (mrdy !== 1'b0 || ostc !== 8'h01) begin
          bad++; $display("FAIL wait_cnt255 mrdy=%b ostc=%h exp 0/01", mrdy, ostc);
        end
      end
      if (j == 257) begin
        total++;
        if (mrdy !== 1'b1 || ostc !== 8'hff) begin
          bad++; $display("FAIL wait_run mrdy=%b ostc=%h exp 1/ff", mrdy, ostc);
        end
      end
      if (j == 258) begin
        total++;
        if (oscoutm !== 1'b1) begin bad++; $display("FAIL run_oscoutm got=%b exp=1", oscoutm); end
      end
    end
  endtask

  task automatic test_abort();
    mstop = 1;
    tick();
    total++;
    if (mrdy !== 1'b0) begin bad++; $display("FAIL stop_mrdy got=%b exp=0", mrdy); end
    osts = 3'd2; mstop = 0;
    for (int j = 1; j <= 501; j++) begin
      tick();
      if (j == 1) osts = 3'd0;
    end
    total++;
    if (ostc !== 8'h01) begin bad++; $display("FAIL abort_cnt500 ostc=%h exp=01", ostc); end
    mstop = 1;
    tick();
    total++;
    if (ostc !== 8'h00 || mrdy !== 1'b0) begin
      bad++; $display("FAIL abort_stop ostc=%h mrdy=%b exp 00/0", ostc, mrdy);
    end
    osts = 3'd2; mstop = 0;
    for (int j = 1; j <= 1025; j++) begin
      tick();
      if (j == 1) osts = 3'd0;
      if (j == 1024) begin
        total++;
        if (mrdy !== 1'b0 || ostc !== 8'h07) begin
          bad++; $display("FAIL rewait_cnt1023 mrdy=%b ostc=%h exp 0/07", mrdy, ostc);
        end
      end
      if (j == 1025) begin
        total++;
        if (mrdy !== 1'b1) begin bad++; $display("FAIL rewait_run mrdy=%b exp=1", mrdy); end
      end
    end
  endtask

  task automatic test_bypass();
    mstop = 1;
    tick();
    exclk = 1; mstop = 0;
    tick();
    total++;
    if (mrdy !== 1'b1 || oscoutm !== 1'b0) begin
      bad++; $display("FAIL exclk_bypass mrdy=%b oscoutm=%b exp 1/0", mrdy, oscoutm);
    end
    @(negedge clk); #1;
    total++;
    if (oscoutm !== 1'b0) begin bad++; $display("FAIL gate_low got=%b exp=0", oscoutm); end
    @(posedge clk); #1;
    total++;
    if (oscoutm !== 1'b1) begin bad++; $display("FAIL gate_first got=%b exp=1", oscoutm); end
    #3;
    total++;
    if (oscoutm !== 1'b1) begin bad++; $display("FAIL gate_width got=%b exp=1", oscoutm); end
    x2 = 1; #1;
    total++;
    if (cputmclk !== 1'b0) begin bad++; $display("FAIL cputmclk_inv_x2hi got=%b exp=0", cputmclk); end
    x2 = 0; #1;
    total++;
    if (cputmclk !== 1'b1) begin bad++; $display("FAIL cputmclk_inv_x2lo got=%b exp=1", cputmclk); end
    exclk = 0; x2 = 1; #1;
    total++;
    if (cputmclk !== 1'b1) begin bad++; $display("FAIL cputmclk_osc got=%b exp=1", cputmclk); end
    x2 = 0; mstop = 1;
    tick();
    mdlycut = 1; mstop = 0;
    tick();
    total++;
    if (mrdy !== 1'b1) begin bad++; $display("FAIL mdlycut_bypass mrdy=%b exp=1", mrdy); end
    mstop = 1; mdlycut = 0;
    tick();
  endtask

  task automatic test_filter();
    bit seen;
    oscsel = 0; mstop = 0; exclk = 0; x1eni = 0; x2eni = 1; x2 = 0; x1 = 0;
    repeat (6) tick();
    total++;
    if (x2din !== 1'b0) begin bad++; $display("FAIL nf_idle got=%b exp=0", x2din); end
    x2 = 1;
    tick();
    x2 = 0;
    seen = 0;
    repeat (8) begin
      tick();
      if (x2din !== 1'b0) seen = 1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL nf_glitch x2din went=1 exp=0"); end
    x2 = 1;
    for (int j = 1; j <= 6; j++) begin
      tick();
      if (j == 4) begin
        total++;
        if (x2din !== 1'b0) begin bad++; $display("FAIL nf_rise_early got=%b exp=0", x2din); end
      end
      if (j == 5) begin
        total++;
        if (x2din !== 1'b1) begin bad++; $display("FAIL nf_rise got=%b exp=1", x2din); end
      end
    end
    x2 = 0;
    for (int j = 1; j <= 5; j++) begin
      tick();
      if (j == 4) begin
        total++;
        if (x2din !== 1'b1) begin bad++; $display("FAIL nf_fall_early got=%b exp=1", x2din); end
      end
      if (j == 5) begin
        total++;
        if (x2din !== 1'b0) begin bad++; $display("FAIL nf_fall got=%b exp=0", x2din); end
      end
    end
    mdlycut = 1; x2 = 1; #1;
    total++;
    if (x2din !== 1'b1) begin bad++; $display("FAIL nf_cut_hi got=%b exp=1", x2din); end
    x2 = 0; #1;
    total++;
    if (x2din !== 1'b0) begin bad++; $display("FAIL nf_cut_lo got=%b exp=0", x2din); end
    x1eni = 1; x1 = 1; #1;
    total++;
    if (x1din !== 1'b1) begin bad++; $display("FAIL x1_cut_hi got=%b exp=1", x1din); end
    x1eni = 0; #1;
    total++;
    if (x1din !== 1'b0) begin bad++; $display("FAIL x1_eni_off got=%b exp=0", x1din); end
    x1eni = 1; mstop = 1; oscsel = 1; #1;
    total++;
    if (x1din !== 1'b0) begin bad++; $display("FAIL x1_osc_mask got=%b exp=0", x1din); end
    x2 = 1; #1;
    total++;
    if (x2din !== 1'b0) begin bad++; $display("FAIL x2_osc_mask got=%b exp=0", x2din); end
    x1 = 0; x2 = 0; x1eni = 0; x2eni = 0; mdlycut = 0;
    tick();
  endtask

  task automatic test_reset_run();
    oscsel = 1; exclk = 1; mstop = 0;
    tick();
    total++;
    if (mrdy !== 1'b1) begin bad++; $display("FAIL rr_run mrdy=%b exp=1", mrdy); end
    repeat (3) tick();
    #2 resetb = 0;
    tick();
    total++;
    if (mrdy !== 1'b0 || ostc !== 8'h00) begin
      bad++; $display("FAIL rr_reset mrdy=%b ostc=%h exp 0/00", mrdy, ostc);
    end
    tick();
    total++;
    if (oscoutm !== 1'b0) begin bad++; $display("FAIL rr_gate got=%b exp=0", oscoutm); end
    repeat (3) tick();
    total++;
    if (runts != 0) begin bad++; $display("FAIL runt_pulses got=%0d exp=0", runts); end
    resetb = 1;
    tick();
  endtask

`ifdef QAHMOS_ICE_OSTC_RDYINT_EN
  task automatic test_rdyint();
    mstop = 1;
    tick();
    rdy_cnt = 0;
    exclk = 0; mstop = 0; osts = 3'd0;
    repeat (10) tick();
    mstop = 1;
    tick();
    total++;
    if (rdy_cnt != 0) begin bad++; $display("FAIL rdyint_abort got=%0d exp=0", rdy_cnt); end
    mstop = 0;
    repeat (260) tick();
    total++;
    if (rdy_cnt != 1) begin bad++; $display("FAIL rdyint_wait got=%0d exp=1", rdy_cnt); end
    mstop = 1;
    tick();
    exclk = 1; mstop = 0;
    repeat (4) tick();
    total++;
    if (rdy_cnt != 2) begin bad++; $display("FAIL rdyint_bypass got=%0d exp=2", rdy_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_wait();
    test_abort();
    test_bypass();
    test_filter();
    test_reset_run();
`ifdef QAHMOS_ICE_OSTC_RDYINT_EN
    test_rdyint();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
